ps2_key_decoder: RTL and testbench

Receives the raw PS/2 keyboard clock/data pair and decodes Set-2 scancode frames. It also tracks the E0 (extended) and F0 (release) prefixes. It produces the 11-bit `ps2_key` event word consumed by the keyboard matrix in the ZX81 top level. It sits between the board's PS/2 pins and `fpga_zx81.ps2_key`, and runs entirely in the `clk_sys` domain.

---
 rtl/ps2_key_decoder.sv | 165 ++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// PS/2 Set-2 scancode receiver: pin sync + clock filter, frame FSM with timeout, E0/F0/E1 prefix tracking.
// Optional PS2_PARITY_CHECK_EN: when defined, a bad odd-parity bit discards the frame.
module ps2_key_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 52000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        key_strobe,
  output logic        frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TO_ONE   = TW'(1);
  localparam logic [7:0]    FLT_LAST = 8'(FILTER_LEN - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  logic          clk_s1, clk_s2, data_s1, data_s2;
  logic          clk_f, clk_f_d, fall;
  logic [7:0]    flt_cnt;
  logic [1:0]    state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic [7:0]    byte_q;
  logic          byte_valid;
  logic [TW-1:0] tcnt;
  logic          frame_ok;
  logic          ext, rel;
  logic [2:0]    skip;

  // Synchronisers and clock glitch filter; the idle bus level is 1.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
      clk_f   <= 1'b1;
      clk_f_d <= 1'b1;
      flt_cnt <= '0;
      fall    <= 1'b0;
    end else begin
      clk_s1  <= ps2_clk;
      clk_s2  <= clk_s1;
      data_s1 <= ps2_data;
      data_s2 <= data_s1;
      clk_f_d <= clk_f;
      fall    <= clk_f_d & ~clk_f;
      if (clk_s2 == clk_f) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FLT_LAST) begin
        clk_f   <= clk_s2;
        flt_cnt <= '0;
      end else begin
        flt_cnt <= flt_cnt + 8'd1;
      end
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  logic par_bit;
  always_ff @(posedge clk_sys) begin
    if (reset)
      par_bit <= 1'b0;
    else if (fall && state == S_PARITY)
      par_bit <= data_s2;
  end
  assign frame_ok = data_s2 & (^{shift, par_bit});
`else
  assign frame_ok = data_s2;
`endif

  // Frame FSM; a fall in the timeout terminal cycle wins over the timeout.
  always_ff @(posedge clk_sys) begin
    frame_err  <= 1'b0;
    byte_valid <= 1'b0;
    if (reset) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      shift   <= '0;
      byte_q  <= '0;
      tcnt    <= '0;
    end else if (fall) begin
      tcnt <= '0;
      case (state)
        S_IDLE: begin
          if (!data_s2) begin
            state   <= S_DATA;
            bit_cnt <= '0;
          end
        end
        S_DATA: begin
          shift   <= {data_s2, shift[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state <= S_PARITY;
        end
        S_PARITY: state <= S_STOP;
        S_STOP: begin
          state <= S_IDLE;
          if (frame_ok) begin
            byte_q     <= shift;
            byte_valid <= 1'b1;
          end else begin
            frame_err <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end else if (state != S_IDLE) begin
      if (tcnt == TO_LAST) begin
        state     <= S_IDLE;
        tcnt      <= '0;
        frame_err <= 1'b1;
      end else begin
        tcnt <= tcnt + TO_ONE;
      end
    end else begin
      tcnt <= '0;
    end
  end

  // Byte handling: Pause skip first, then prefixes, then housekeeping bytes, then key events.
  always_ff @(posedge clk_sys) begin
    key_strobe <= 1'b0;
    if (reset) begin
      ps2_key <= '0;
      ext     <= 1'b0;
      rel     <= 1'b0;
      skip    <= '0;
    end else if (byte_valid) begin
      if (skip != 3'd0) begin
        skip <= skip - 3'd1;
      end else begin
        case (byte_q)
          8'hE1: begin
            skip <= 3'd7;
            ext  <= 1'b0;
            rel  <= 1'b0;
          end
          8'hE0: ext <= 1'b1;
          8'hF0: rel <= 1'b1;
          8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF: begin
            ext <= 1'b0;
            rel <= 1'b0;
          end
          default: begin
            ps2_key    <= {~ps2_key[10], ~rel, ext, byte_q};
            key_strobe <= 1'b1;
            ext        <= 1'b0;
            rel        <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: directed vector table, hand-written corner sequences, and random frames vs a byte-level model.
module tb_ps2_key_decoder;

  localparam int FL   = 4;
  localparam int TO   = 2000;
  localparam int HALF = 100;
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        ps2_clk;
  logic        ps2_data;
  logic [10:0] ps2_key;
  logic        key_strobe;
  logic        frame_err;

  ps2_key_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk_sys   (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .ps2_key   (ps2_key),
    .key_strobe(key_strobe),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n_strobe = 0;
  int n_err    = 0;
  logic [10:0] exp_q[$];

  // Byte-level reference model state.
  bit m_b10, m_ext, m_rel;
  int m_skip;
  int m_err_exp;

  typedef struct {
    logic [7:0] data;
    bit         bad_par;
    bit         ev;
    bit         err;
    logic [9:0] key10;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mk(logic [7:0] d, bit bp, bit ev, bit err, logic [9:0] k);
    vec_t v;
    v.data = d; v.bad_par = bp; v.ev = ev; v.err = err; v.key10 = k;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every strobe must match the next expected event.
  initial begin
    logic prev_strobe;
    logic [10:0] e;
    prev_strobe = 1'b0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b0) begin
        prev_strobe = 1'b0;
      end else begin
        if (key_strobe) begin
          n_strobe++;
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL strobe_unexpected: got key %h want no event", ps2_key);
          end else begin
            e = exp_q.pop_front();
            if (ps2_key !== e) begin
              bad++;
              $display("FAIL event_key: got %h want %h", ps2_key, e);
            end
          end
          total++;
          if (prev_strobe) begin
            bad++;
            $display("FAIL strobe_spacing: got back-to-back strobes want isolated");
          end
        end
        if (frame_err) n_err++;
        prev_strobe = key_strobe;
      end
    end
  end

  task automatic model_reset();
    m_b10 = 0; m_ext = 0; m_rel = 0; m_skip = 0;
    exp_q.delete();
  endtask

  task automatic model_byte(input logic [7:0] b, input bit ok);
    if (!ok) begin
      m_err_exp++;
    end else if (m_skip > 0) begin
      m_skip--;
    end else if (b == 8'hE1) begin
      m_skip = 7; m_ext = 0; m_rel = 0;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_rel = 1;
    end else if (b inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF}) begin
      m_ext = 0; m_rel = 0;
    end else begin
      m_b10 = ~m_b10;
      exp_q.push_back({m_b10, ~m_rel, m_ext, b});
      m_ext = 0; m_rel = 0;
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    ps2_data = b;
    repeat (HALF / 2) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (HALF / 2) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    model_byte(b, !bad_stop && !(bad_par && PAR_EN));
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ bad_par);
    send_bit(~bad_stop);
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  initial begin
    int s0, e0;
    bit tb_b10;
    logic [9:0] cur10;
    logic [7:0] rb;
    bit rp, rs;

    reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    m_err_exp = 0;
    model_reset();
    repeat (5) @(negedge clk);
    check("rst_key", ps2_key, 11'h000);
    check("rst_strobe", key_strobe, 1'b0);
    check("rst_err", frame_err, 1'b0);
    check("rst_state", dut.state, 2'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);

    tbl[0]  = mk(8'h1C, 0, 1, 0, 10'h21C);
    tbl[1]  = mk(8'hE0, 0, 0, 0, 10'h000);
    tbl[2]  = mk(8'hF0, 0, 0, 0, 10'h000);
    tbl[3]  = mk(8'h75, 0, 1, 0, 10'h175);
    if (PAR_EN) tbl[4] = mk(8'h1C, 1, 0, 1, 10'h000);
    else        tbl[4] = mk(8'h1C, 1, 1, 0, 10'h21C);
    tbl[5]  = mk(8'hF0, 0, 0, 0, 10'h000);
    tbl[6]  = mk(8'hAA, 0, 0, 0, 10'h000);
    tbl[7]  = mk(8'h1C, 0, 1, 0, 10'h21C);
    tbl[8]  = mk(8'hE1, 0, 0, 0, 10'h000);
    tbl[9]  = mk(8'h14, 0, 0, 0, 10'h000);
    tbl[10] = mk(8'h77, 0, 0, 0, 10'h000);
    tbl[11] = mk(8'hE1, 0, 0, 0, 10'h000);
    tbl[12] = mk(8'hF0, 0, 0, 0, 10'h000);
    tbl[13] = mk(8'h14, 0, 0, 0, 10'h000);
    tbl[14] = mk(8'hF0, 0, 0, 0, 10'h000);
    tbl[15] = mk(8'h77, 0, 0, 0, 10'h000);
    tbl[16] = mk(8'hAA, 0, 0, 0, 10'h000);
    tbl[17] = mk(8'h5A, 0, 1, 0, 10'h25A);

    tb_b10 = 0;
    cur10  = 10'h000;
    for (int i = 0; i < 18; i++) begin
      s0 = n_strobe; e0 = n_err;
      send_byte(tbl[i].data, tbl[i].bad_par, 1'b0);
      repeat (20) @(negedge clk);
      check($sformatf("tbl%0d_strobes", i), n_strobe - s0, tbl[i].ev);
      check($sformatf("tbl%0d_err", i), n_err - e0, tbl[i].err);
      if (tbl[i].ev) begin
        tb_b10 = ~tb_b10;
        cur10  = tbl[i].key10;
      end
      check($sformatf("tbl%0d_key", i), ps2_key, {tb_b10, cur10});
    end

    // Timeout after 5 data bits, then recovery.
    s0 = n_strobe; e0 = n_err;
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    repeat (3000) @(negedge clk);
    check("timeout_err", n_err - e0, 1);
    check("timeout_strobes", n_strobe - s0, 0);
    check("timeout_idle", dut.state, 2'd0);
    send_byte(8'h29, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    tb_b10 = ~tb_b10;
    check("recover_key", ps2_key, {tb_b10, 10'h229});

    // Short low glitch with data low must not start a frame.
    s0 = n_strobe; e0 = n_err;
    @(negedge clk);
    ps2_data = 1'b0; ps2_clk = 1'b0;
    repeat (2) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (20) @(negedge clk);
    ps2_data = 1'b1;
    check("glitch_idle", dut.state, 2'd0);
    repeat (TO + 100) @(negedge clk);
    check("glitch_err", n_err - e0, 0);
    check("glitch_strobes", n_strobe - s0, 0);

    // Reset during bit 3 of a frame.
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    @(negedge clk);
    ps2_data = 1'b1;
    repeat (HALF / 2) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF / 2) @(negedge clk);
    reset = 1'b1;
    ps2_clk = 1'b1;
    repeat (5) @(negedge clk);
    check("midrst_key", ps2_key, 11'h000);
    check("midrst_strobe", key_strobe, 1'b0);
    check("midrst_state", dut.state, 2'd0);
    model_reset();
    tb_b10 = 0;
    reset = 1'b0;
    repeat (50) @(negedge clk);
    send_byte(8'h1C, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    check("postrst_key", ps2_key, 11'h61C);

    // Random frames against the model.
    e0 = n_err;
    m_err_exp = 0;
    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(0, 9))
        0: rb = 8'hE0;
        1: rb = 8'hF0;
        2: rb = 8'hAA;
        default: rb = 8'($urandom_range(1, 254));
      endcase
      rp = ($urandom_range(0, 5) == 0);
      rs = ($urandom_range(0, 7) == 0);
      send_byte(rb, rp, rs);
    end
    repeat (20) @(negedge clk);
    check("rand_errs", n_err - e0, m_err_exp);
    check("pending_events", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
